// File: rtl/kgp_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGPRisc core.
// Optional memory-timeout fault (wait counter plus ERR state) is enabled with `define SEQ_TIMEOUT_EN.
module kgp_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic [5:0]       opcode,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic [11:0]      br_sel,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_s,
  input  logic             flag_v,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             flag_we,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_IMM = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             mem_we_q;
  logic [CNT_W-1:0] instr_count_q;
  logic             cond_taken;
  logic             alu_op;

  // Register writes are implied by instruction class, so reg_write is not consulted.
  logic unused_inputs;
  assign unused_inputs = reg_write;

  function automatic logic is_alu_op(input logic [5:0] op);
    is_alu_op = (op <= 6'h05) ||
                ((op >= 6'h0C) && (op <= 6'h0E)) ||
                ((op >= 6'h10) && (op <= 6'h12));
  endfunction

  always_comb begin
    alu_op     = is_alu_op(opcode);
    cond_taken = (br_sel[9] &  flag_z) | (br_sel[8] & ~flag_z) |
                 (br_sel[7] &  flag_c) | (br_sel[6] & ~flag_c) |
                 (br_sel[5] &  flag_s) | (br_sel[4] & ~flag_s) |
                 (br_sel[3] &  flag_v) | (br_sel[2] & ~flag_v);
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [WAIT_W-1:0] wait_q;
  logic              err_q;
  logic              wait_expired;

  assign wait_expired = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack &&
                        (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = PC_INC;
    rf_we   = 1'b0;
    wb_sel  = WB_ALU;
    flag_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (|br_sel) begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
          if (br_sel[11]) begin
            pc_sel = PC_IMM;
          end else if (br_sel[10] || br_sel[0]) begin
            pc_sel = PC_REG;
          end else if (br_sel[1]) begin
            pc_sel = PC_IMM;
            rf_we  = 1'b1;
            wb_sel = WB_LINK;
          end else begin
            pc_sel = cond_taken ? PC_IMM : PC_INC;
          end
        end else if (mem_read || mem_write) begin
          state_d = S_MEM;
        end else if (alu_op) begin
          flag_we = 1'b1;
          state_d = S_WB;
        end else begin
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          if (mem_we_q) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        wb_sel  = mem_to_reg ? WB_MEM : WB_ALU;
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
`ifdef SEQ_TIMEOUT_EN
      S_ERR: state_d = S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_FETCH) && halt) state_d = S_IDLE;

`ifdef SEQ_TIMEOUT_EN
    if (wait_expired) state_d = S_ERR;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mem_we_q      <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC) mem_we_q <= mem_write;
      if (pc_we) instr_count_q <= instr_count_q + CNT_W'(1);
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Counter restarts on every state change, so each FETCH/MEM visit gets a fresh budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
      if (state_d == S_ERR) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    mem_req      = (state_q == S_FETCH) || (state_q == S_MEM);
    mem_addr_sel = (state_q == S_MEM);
    mem_we       = (state_q == S_MEM) && mem_we_q;
    busy         = (state_q != S_IDLE);
    state        = state_q;
    instr_count  = instr_count_q;
  end

endmodule

// File: tb/tb_kgp_sequencer.sv
// Directed self-checking bench for kgp_sequencer (CNT_W=4 so the retire counter wraps quickly).
module tb_kgp_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt;
  logic [5:0]  opcode;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic [11:0] br_sel;
  logic        flag_z;
  logic        flag_c;
  logic        flag_s;
  logic        flag_v;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        flag_we;
  logic        busy;
  logic [2:0]  state;
  logic [3:0]  instr_count;
  logic        err;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  kgp_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .opcode(opcode),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .br_sel(br_sel), .flag_z(flag_z), .flag_c(flag_c),
    .flag_s(flag_s), .flag_v(flag_v), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .flag_we(flag_we),
    .busy(busy), .state(state), .instr_count(instr_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic mr, input logic mw,
                           input logic rw, input logic m2r, input logic [11:0] br);
    opcode     = op;
    mem_read   = mr;
    mem_write  = mw;
    reg_write  = rw;
    mem_to_reg = m2r;
    br_sel     = br;
  endtask

  // From IDLE: pulse start, land in FETCH.
  task automatic do_start();
    start = 1'b1;
    settle();
    chk("idle_before_start", state, 0);
    step();
    start = 1'b0;
  endtask

  // Zero-wait fetch followed by DECODE; leaves the bench at the EXEC cycle.
  task automatic fetch_decode(input string tag);
    mem_ack = 1'b1;
    settle();
    chk({tag, "_fetch_state"}, state, 1);
    chk({tag, "_fetch_irwe"}, ir_we, 1);
    chk({tag, "_fetch_req"}, {mem_req, mem_addr_sel, mem_we}, 3'b100);
    step();
    mem_ack = 1'b0;
    settle();
    chk({tag, "_decode"}, {state, ir_we, pc_we, rf_we, flag_we}, {3'd2, 4'b0000});
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; mem_ack = 1'b0;
    flag_z = 1'b0; flag_c = 1'b0; flag_s = 1'b0; flag_v = 1'b0;
    set_instr(6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step();
    step();
    chk("reset_state", state, 0);
    chk("reset_outs", {mem_req, busy, err, pc_we, ir_we}, 5'b00000);
    chk("reset_count", instr_count, 0);
    rst = 1'b0;
    step();
    settle();
    chk("idle_hold", state, 0);

    // addi, zero-wait: ir_we c1, flag_we c3, rf_we+pc_we c4
    do_start();
    set_instr(6'h01, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    fetch_decode("addi");
    settle();
    chk("addi_exec", {state, flag_we, pc_we, rf_we}, {3'd3, 3'b100});
    step();
    settle();
    chk("addi_wb", {state, rf_we, pc_we, wb_sel, pc_sel}, {3'd5, 2'b11, 2'b00, 2'b00});
    step();
    exp_cnt = 1;
    chk("addi_count", instr_count, exp_cnt);

    // LW with 3 wait cycles in MEM
    set_instr(6'h08, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
    fetch_decode("lw");
    settle();
    chk("lw_exec", {state, pc_we, flag_we}, {3'd3, 2'b00});
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      settle();
      chk("lw_mem_req", {state, mem_req, mem_addr_sel, mem_we, pc_we}, {3'd4, 4'b1100});
      step();
    end
    mem_ack = 1'b0;
    settle();
    chk("lw_wb", {state, rf_we, wb_sel, pc_we, pc_sel}, {3'd5, 1'b1, 2'b01, 1'b1, 2'b00});
    step();
    exp_cnt = 2;
    chk("lw_count", instr_count, exp_cnt);

    // SW zero-wait
    set_instr(6'h09, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    fetch_decode("sw");
    step();
    mem_ack = 1'b1;
    settle();
    chk("sw_mem", {state, mem_req, mem_we, mem_addr_sel, pc_we, pc_sel, rf_we},
        {3'd4, 4'b1111, 2'b00, 1'b0});
    step();
    mem_ack = 1'b0;
    exp_cnt = 3;
    chk("sw_fetch", {state, instr_count}, {3'd1, 4'(exp_cnt)});

    // bz taken / not taken
    set_instr(6'h20, 1'b0, 1'b0, 1'b0, 1'b0, 12'h200);
    flag_z = 1'b1;
    fetch_decode("bz_t");
    settle();
    chk("bz_taken", {state, pc_we, pc_sel, rf_we}, {3'd3, 1'b1, 2'b01, 1'b0});
    step();
    flag_z = 1'b0;
    fetch_decode("bz_nt");
    settle();
    chk("bz_not_taken", {pc_we, pc_sel}, 3'b100);
    step();

    // Call and Ret
    set_instr(6'h28, 1'b0, 1'b0, 1'b1, 1'b0, 12'h002);
    fetch_decode("call");
    settle();
    chk("call_exec", {pc_we, pc_sel, rf_we, wb_sel}, {1'b1, 2'b01, 1'b1, 2'b10});
    step();
    set_instr(6'h29, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001);
    fetch_decode("ret");
    settle();
    chk("ret_exec", {pc_we, pc_sel, rf_we}, {1'b1, 2'b10, 1'b0});
    step();

    // bcy taken on carry, then an unknown opcode as NOP
    set_instr(6'h22, 1'b0, 1'b0, 1'b0, 1'b0, 12'h080);
    flag_c = 1'b1;
    fetch_decode("bcy");
    settle();
    chk("bcy_taken", {pc_we, pc_sel}, 3'b101);
    step();
    flag_c = 1'b0;
    set_instr(6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    fetch_decode("nop");
    settle();
    chk("nop_exec", {pc_we, pc_sel, flag_we, rf_we}, 5'b10000);
    step();
    exp_cnt = 9;
    chk("count_9", instr_count, exp_cnt);

    // b with halt raised in EXEC: retires, then IDLE
    set_instr(6'h21, 1'b0, 1'b0, 1'b0, 1'b0, 12'h800);
    fetch_decode("b_halt");
    halt = 1'b1;
    settle();
    chk("b_exec", {pc_we, pc_sel}, 3'b101);
    step();
    halt = 1'b0;
    exp_cnt = 10;
    chk("halt_idle", {state, busy, mem_req}, {3'd0, 2'b00});
    chk("halt_count", instr_count, exp_cnt);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ack_ignored_idle", state, 0);

    // six NOPs: 10 -> 15 -> wraps to 0 on the last, which also halts
    do_start();
    set_instr(6'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    for (int i = 0; i < 6; i++) begin
      fetch_decode("wrap");
      halt = (i == 5);
      step();
      halt = 1'b0;
      if (i == 4) chk("count_15", instr_count, 15);
    end
    chk("count_wrap", {state, instr_count}, {3'd0, 4'd0});

    // reset mid-MEM of a load with no ack
    do_start();
    set_instr(6'h08, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
    fetch_decode("rst_lw");
    step();
    settle();
    chk("rst_lw_in_mem", {state, mem_req}, {3'd4, 1'b1});
    rst = 1'b1;
    #1;
    chk("rst_async", {state, mem_req, busy, pc_we, rf_we}, {3'd0, 4'b0000});
    chk("rst_async_count", instr_count, 0);
    step();
    rst = 1'b0;
    set_instr(6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step();
    chk("rst_release_idle", state, 0);
    step();
    chk("rst_release_idle2", {state, busy}, {3'd0, 1'b0});

    // FETCH with no ack for 16 cycles
    do_start();
    mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("wait_fetch", {state, mem_req, err}, {3'd1, 2'b10});
      step();
    end
    settle();
`ifdef SEQ_TIMEOUT_EN
    chk("timeout_err", {state, err, mem_req, busy}, {3'd6, 3'b101});
    mem_ack = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    mem_ack = 1'b0;
    chk("err_sticky", {state, err, mem_req}, {3'd6, 2'b10});
    rst = 1'b1;
    #1;
    chk("err_cleared", {state, err}, {3'd0, 1'b0});
    step();
    rst = 1'b0;
`else
    chk("no_timeout", {state, err, mem_req}, {3'd1, 2'b01});
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("late_ack_decode", {state, err}, {3'd2, 1'b0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kgp_sequencer.md
# kgp_sequencer

Multi-cycle instruction sequencer for the KGPRisc core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, driving the memory handshake and the datapath write enables. It consumes the control unit's decoded strobes, the flag register and the memory acknowledge. It produces the PC/IR/register-file/flag write pulses and a retired-instruction counter.

## Interface

Parameters:
- TIMEOUT_CYCLES, 16, wait cycles without `mem_ack` before fault (used only with SEQ_TIMEOUT_EN)
- CNT_W, 16, width of `instr_count`

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  leave IDLE and begin fetching
- halt  in  1  stop at the next instruction boundary
- opcode  in  6  instruction opcode from IR; valid from DECODE onward
- mem_read, mem_write, reg_write, mem_to_reg  in  1 each  decoded control strobes
- br_sel  in  12  one-hot {b,br,bz,bnz,bcy,bncy,bs,bns,bv,bnv,Call,Ret}, bit 11..0
- flag_z, flag_c, flag_s, flag_v  in  1 each  flag register outputs
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  request is a write
- mem_addr_sel  out  1  address source: 0 = PC, 1 = ALU result
- ir_we  out  1  load IR
- pc_we  out  1  load PC
- pc_sel  out  2  PC source: 00 = PC+1, 01 = immediate target, 10 = register/ALU target
- rf_we  out  1  register file write
- wb_sel  out  2  write-back source: 00 = ALU, 01 = memory, 10 = PC+1 (link)
- flag_we  out  1  update flag register
- busy  out  1  state != IDLE
- state  out  3  current state, for debug
- instr_count  out  CNT_W  retired instructions
- err  out  1  sticky memory-timeout fault

## Operation

States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.

- **IDLE**: all strobes 0. `start` moves to FETCH.
- **FETCH**: `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - Hold until `mem_ack`.
  - On the ack cycle, `ir_we`=1 and the next state is DECODE.
- **DECODE**: one cycle, no strobes, then EXEC.
- **EXEC**, by instruction class:
  - ALU/shift ops (opcodes 0x00–0x05, 0x0C–0x0E, 0x10–0x12): `flag_we`=1, then WB.
  - LW/SW: go to MEM.
  - Conditional branches: taken when the selected condition holds (bz: `flag_z`; bnz: !`flag_z`; bcy/bncy on `flag_c`; bs/bns on `flag_s`; bv/bnv on `flag_v`).
    - Taken: `pc_we`=1, `pc_sel`=01.
    - Not taken: `pc_we`=1, `pc_sel`=00.
    - Then FETCH.
  - b: `pc_sel`=01. br: `pc_sel`=10. Both with `pc_we`=1, then FETCH.
  - Call: `rf_we`=1, `wb_sel`=10, `pc_we`=1, `pc_sel`=01, then FETCH.
  - Ret: `pc_we`=1, `pc_sel`=10, then FETCH.
  - Any other opcode is a NOP: `pc_we`=1, `pc_sel`=00, then FETCH.
- **MEM**: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=`mem_write`.
  - Hold until `mem_ack`.
  - Store: on ack, `pc_we`=1, `pc_sel`=00, then FETCH.
  - Load: on ack, go to WB.
- **WB**: `rf_we`=1, `wb_sel`=`mem_to_reg`?01:00, `pc_we`=1, `pc_sel`=00, then FETCH.
- **Halt and retire**:
  - Wherever the next state would be FETCH and `halt`=1, go to IDLE instead; the instruction still retires.
  - `instr_count` increments on every `pc_we` pulse and wraps to 0 after all ones.
- **Reset**:
  - Asserting `rst` in any state forces IDLE, `instr_count`=0, `err`=0, and every output 0 in the same cycle.
  - An outstanding memory request is abandoned.

## Timing

- `mem_req`, `mem_we`, `mem_addr_sel`, `busy` and `state` are decoded from state only.
- `ir_we`, `pc_we`, `rf_we`, `wb_sel` and `flag_we` are combinational from state and inputs, one cycle wide.
- `mem_ack` is sampled in the same cycle as `mem_req`, so zero-wait memory acks in the first cycle.
- `mem_req` stays high, with address select unchanged, until the ack.
- A `mem_ack` outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - ALU/shift: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Branch, Call, Ret, NOP: 3 cycles.
- Each memory wait cycle adds 1.
- `start` is ignored outside IDLE. `halt` is sampled only at the FETCH-entry decision.

## Configuration

- **SEQ_TIMEOUT_EN defined**:
  - A wait counter clears on entry to FETCH/MEM and counts cycles without `mem_ack`.
  - When it reaches TIMEOUT_CYCLES, the next state is ERR, `mem_req` drops and `err`=1.
  - ERR is left only by `rst`.
- **SEQ_TIMEOUT_EN undefined**:
  - No counter and no ERR state; waits are unbounded.
  - `err` is tied to 0.

## Test plan

- Reset mid-MEM of an LW with `mem_ack`=0 → immediately `state`=0, `mem_req`=0, `instr_count`=0; after release, stays IDLE until `start`.
- `start`, zero-wait memory, addi (0x01) → `ir_we` at cycle 1, `flag_we` at cycle 3, `rf_we`+`pc_we` (`wb_sel`=00) at cycle 4; `instr_count`=1.
- LW with 3 wait cycles in MEM → `mem_req` high for 4 cycles with `mem_addr_sel`=1; WB `wb_sel`=01; total 8 cycles.
- bz with `flag_z`=1 → `pc_sel`=01; with `flag_z`=0 → `pc_sel`=00; Call → `rf_we`=1, `wb_sel`=10, `pc_sel`=01; Ret → `pc_sel`=10.
- `halt` raised during EXEC of a branch → retires (`instr_count`+1), then IDLE, `busy`=0; CNT_W=4 with 16 retires → `instr_count` wraps to 0.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, `mem_ack` never asserted in FETCH → `err`=1 after 16 wait cycles, `state`=6, `mem_req`=0 until `rst`.
